cursor_update_scheduler: RTL and testbench
==========================================

// Module: cursor_update_scheduler
// PURPOSE
//  Owns the cursor position that feeds the VGA driver's x_pos/y_pos inputs and shares it
//  between two requesters: the button simulator (screen-space deltas) and a PS/2 mouse
//  decoder (mouse-space deltas). Deltas accumulate during the frame and are committed
//  once per frame at the start of vertical blanking, so the cursor never tears mid-frame.
// PARAMETERS
//  H_ACTIVE  640  visible columns; x_pos is clamped to [0, H_ACTIVE-1]
//  V_ACTIVE  480  visible lines;   y_pos is clamped to [0, V_ACTIVE-1]
//  D_W       9    width of signed two's-complement delta inputs
//  ACC_W     12   width of signed per-axis accumulators (saturating)
// PORTS
//  clk_in      in   1       25 MHz pixel clock (same clock as the VGA synchronizer)
//  rst_n       in   1       asynchronous, active-low reset
//  frame_tick  in   1       1-cycle pulse at the first blanking line of each frame
//  btn_valid   in   1       button requester has a delta
//  btn_ready   out  1       button delta accepted when btn_valid && btn_ready
//  btn_dx      in   D_W     signed x delta, screen space (+ = right)
//  btn_dy      in   D_W     signed y delta, screen space (+ = down)
//  ms_valid    in   1       mouse requester has a packet
//  ms_ready    out  1       mouse packet accepted when ms_valid && ms_ready
//  ms_dx       in   D_W     signed x delta (+ = right)
//  ms_dy       in   D_W     signed y delta, PS/2 convention (+ = up)
//  ms_buttons  in   3       L/R/M button state carried with the packet
//  x_pos       out  10      committed cursor column
//  y_pos       out  10      committed cursor line
//  buttons     out  3       button state of the last accepted mouse packet, committed per frame
//  sat_flag    out  1       sticky: an accumulator saturated since reset
// BEHAVIOUR
//  Reset (async, rst_n=0): x_pos=H_ACTIVE/2 (320), y_pos=V_ACTIVE/2 (240), buttons=0,
//   sat_flag=0, accumulators=0, rr_last=mouse, state=ACCUM, btn_ready=ms_ready=0.
//  FSM: ACCUM -> COMMIT_X -> COMMIT_Y -> ACCUM.
//   ACCUM: the arbiter asserts at most one ready per cycle.
//    Only one valid: that requester is granted. Both valid: round-robin; grant the one not
//    granted last (rr_last), update rr_last on each accepted transfer.
//    Readies are combinational from valid and rr_last; a requester may drop valid without penalty.
//    Accepted delta: acc_x += dx; acc_y += dy (button) or acc_y -= dy (mouse, y inverted).
//    Deltas are sign-extended to ACC_W. The sum saturates at +/-(2^(ACC_W-1)-1).
//    Saturation sets sat_flag.
//    Mouse accept also latches ms_buttons into a pending register.
//    frame_tick in ACCUM -> COMMIT_X next cycle. A transfer accepted in the same cycle as
//    frame_tick is included in this frame's commit.
//   COMMIT_X (1 cycle): readies=0; x_pos <= clamp(x_pos + acc_x, 0, H_ACTIVE-1); acc_x <= 0;
//    buttons <= pending buttons.
//   COMMIT_Y (1 cycle): readies=0; y_pos <= clamp(y_pos + acc_y, 0, V_ACTIVE-1); acc_y <= 0.
//  Latency: an accepted delta is visible on x_pos 2 cycles and on y_pos 3 cycles after the
//   next frame_tick. Outputs are registered and change only in COMMIT_X/COMMIT_Y.
//  Arithmetic: clamp computed in ACC_W+1 signed bits; result <0 -> 0; result >= limit -> limit-1.
//  frame_tick asserted in COMMIT_X/COMMIT_Y is ignored (no queued commit).
//  rst_n asserted mid-commit returns immediately to reset values; partial commits are discarded.
//  No delta is lost or duplicated across the ACCUM/COMMIT boundary.
// STRUCTURE
//  Shared header cursor_defs.vh: H_ACTIVE, V_ACTIVE, ACC_W defaults, FSM state encodings
//   (ACCUM=2'd0, COMMIT_X=2'd1, COMMIT_Y=2'd2), and the REQ_BTN/REQ_MS ids for rr_last.
//  One sub-module, cursor_axis_accum, instantiated twice (x, y). It holds the saturating
//   accumulator, a clear input, and the clamp-to-limit position adder.
//  The top level holds the FSM, the round-robin arbiter, the button latch and sat_flag.
// TESTING
//  1 Reset: rst_n=0 mid-frame -> x_pos=320, y_pos=240, buttons=0, both readies 0.
//  2 Single button: btn dx=+5, dy=+3, then frame_tick -> x_pos=325 at tick+2, y_pos=243 at tick+3.
//  3 Contention: both valid for 4 cycles -> grants alternate; ms dx=+1, dy=+1, btn dx=+1, dy=0
//    (x2 each) -> x +4, y -2.
//  4 Clamp: x_pos=630, btn dx=+100 -> x_pos=639; y_pos=2, btn dy=-50 -> y_pos=0.
//  5 Boundary: transfer dx=+7 accepted on the frame_tick cycle -> included this frame.
//    frame_tick during COMMIT_X is ignored, and readies stay 0 for exactly 2 cycles.
//  6 Saturation: 20 transfers of dx=+255 -> acc holds at +2047, sat_flag=1, x_pos=639.

Source files
------------

// File: rtl/cursor_update_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cursor_update_scheduler_pkg                                   |
// | Purpose  : Shared constants, FSM state encodings and requester ids for   |
// |            the cursor update scheduler and its per-axis accumulator.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package cursor_update_scheduler_pkg;

  // Default visible raster and datapath widths
  localparam int c_h_active = 640;
  localparam int c_v_active = 480;
  localparam int c_d_w      = 9;
  localparam int c_acc_w    = 12;

  // Committed cursor coordinates are always 10 bits wide (covers 0..1023)
  localparam int c_pos_w    = 10;

  // Commit sequencer: accumulate all frame, then commit X and Y on consecutive cycles
  typedef enum logic [1:0] {
    ACCUM    = 2'd0,
    COMMIT_X = 2'd1,
    COMMIT_Y = 2'd2
  } state_t;

  // Identity of the requester granted most recently, used for round-robin fairness
  typedef enum logic {
    REQ_BTN = 1'b0,
    REQ_MS  = 1'b1
  } req_t;

endpackage : cursor_update_scheduler_pkg
`default_nettype wire

// File: rtl/cursor_update_scheduler_axis_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cursor_axis_accum                                             |
// | Purpose  : One cursor axis: a saturating signed delta accumulator and    |
// |            the committed position register, updated by a clamping adder. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module cursor_axis_accum #(
  parameter int ACC_W     = 12,
  parameter int POS_W     = 10,
  parameter int LIMIT     = 640,
  parameter int RESET_POS = 320
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic                    add_en,
  input  logic signed [ACC_W-1:0] delta,
  input  logic                    clear,
  input  logic                    commit,
  output logic [POS_W-1:0]        pos,
  output logic                    sat
);

  // Saturation bounds are symmetric, so -2^(ACC_W-1) is never produced
  localparam logic signed [ACC_W:0] c_acc_max   = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] c_acc_min   = -c_acc_max;
  localparam logic signed [ACC_W:0] c_limit     = (ACC_W+1)'(LIMIT);
  localparam logic [POS_W-1:0]      c_pos_max   = POS_W'(LIMIT - 1);
  localparam logic [POS_W-1:0]      c_pos_reset = POS_W'(RESET_POS);

  logic signed [ACC_W-1:0] r_acc;
  logic [POS_W-1:0]        r_pos;

  logic signed [ACC_W:0]   w_sum;
  logic signed [ACC_W-1:0] w_acc_next;
  logic                    w_sat;
  logic signed [ACC_W:0]   w_pos_sum;
  logic [POS_W-1:0]        w_pos_next;

  // One guard bit makes every accumulator + delta sum exactly representable
  assign w_sum = {r_acc[ACC_W-1], r_acc} + {delta[ACC_W-1], delta};

  // Position is non-negative; zero-extend it into the same signed width as the accumulator
  assign w_pos_sum = $signed({{(ACC_W+1-POS_W){1'b0}}, r_pos}) + {r_acc[ACC_W-1], r_acc};

  // Saturate the running sum and flag when the bound was actually hit by an accepted delta
  always_comb begin
    w_acc_next = w_sum[ACC_W-1:0];
    w_sat      = 1'b0;
    if (w_sum > c_acc_max) begin
      w_acc_next = c_acc_max[ACC_W-1:0];
      w_sat      = add_en;
    end else if (w_sum < c_acc_min) begin
      w_acc_next = c_acc_min[ACC_W-1:0];
      w_sat      = add_en;
    end
  end

  // Clamp the committed position to the visible range [0, LIMIT-1]
  always_comb begin
    w_pos_next = w_pos_sum[POS_W-1:0];
    if (w_pos_sum < 0) begin
      w_pos_next = '0;
    end else if (w_pos_sum >= c_limit) begin
      w_pos_next = c_pos_max;
    end
  end

  // Accumulator: a clear wins over an add; no add can arrive while clearing
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clear) begin
      r_acc <= '0;
    end else if (add_en) begin
      r_acc <= w_acc_next;
    end
  end

  // Committed position only moves on its commit cycle
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= c_pos_reset;
    end else if (commit) begin
      r_pos <= w_pos_next;
    end
  end

  assign pos = r_pos;
  assign sat = w_sat;

endmodule : cursor_axis_accum
`default_nettype wire

// File: rtl/cursor_update_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cursor_update_scheduler                                       |
// | Purpose  : Arbitrates button and PS/2 mouse cursor deltas, accumulates   |
// |            them during the frame and commits the cursor position once    |
// |            per frame at the start of vertical blanking (tear-free).      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module cursor_update_scheduler
  import cursor_update_scheduler_pkg::*;
#(
  parameter int H_ACTIVE = c_h_active,
  parameter int V_ACTIVE = c_v_active,
  parameter int D_W      = c_d_w,
  parameter int ACC_W    = c_acc_w
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               btn_valid,
  output logic               btn_ready,
  input  logic [D_W-1:0]     btn_dx,
  input  logic [D_W-1:0]     btn_dy,
  input  logic               ms_valid,
  output logic               ms_ready,
  input  logic [D_W-1:0]     ms_dx,
  input  logic [D_W-1:0]     ms_dy,
  input  logic [2:0]         ms_buttons,
  output logic [c_pos_w-1:0] x_pos,
  output logic [c_pos_w-1:0] y_pos,
  output logic [2:0]         buttons,
  output logic               sat_flag
);

  state_t     r_state;
  req_t       r_rr_last;
  logic [2:0] r_btn_pend;
  logic [2:0] r_buttons;
  logic       r_sat_flag;

  logic             w_accum;
  logic             w_btn_grant;
  logic             w_ms_grant;
  logic             w_add;
  logic [ACC_W-1:0] w_btn_dx_ext;
  logic [ACC_W-1:0] w_btn_dy_ext;
  logic [ACC_W-1:0] w_ms_dx_ext;
  logic [ACC_W-1:0] w_ms_dy_ext;
  logic [ACC_W-1:0] w_dx;
  logic [ACC_W-1:0] w_dy;
  logic             w_commit_x;
  logic             w_commit_y;
  logic             w_sat_x;
  logic             w_sat_y;

  // Transfers are only accepted while accumulating, and never while held in reset
  assign w_accum = (r_state == ACCUM) && rst_n;

  // Round-robin: a lone requester always wins; on contention the one not granted last wins
  assign w_btn_grant = w_accum && btn_valid && (!ms_valid || (r_rr_last == REQ_MS));
  assign w_ms_grant  = w_accum && ms_valid  && (!btn_valid || (r_rr_last == REQ_BTN));
  assign w_add       = w_btn_grant || w_ms_grant;

  assign btn_ready = w_btn_grant;
  assign ms_ready  = w_ms_grant;

  // Sign-extend deltas; PS/2 reports +y as up, so the mouse y delta is negated into screen space
  assign w_btn_dx_ext = {{(ACC_W-D_W){btn_dx[D_W-1]}}, btn_dx};
  assign w_btn_dy_ext = {{(ACC_W-D_W){btn_dy[D_W-1]}}, btn_dy};
  assign w_ms_dx_ext  = {{(ACC_W-D_W){ms_dx[D_W-1]}}, ms_dx};
  assign w_ms_dy_ext  = {{(ACC_W-D_W){ms_dy[D_W-1]}}, ms_dy};

  assign w_dx = w_ms_grant ? w_ms_dx_ext  : w_btn_dx_ext;
  assign w_dy = w_ms_grant ? -w_ms_dy_ext : w_btn_dy_ext;

  assign w_commit_x = (r_state == COMMIT_X);
  assign w_commit_y = (r_state == COMMIT_Y);

  cursor_axis_accum #(
    .ACC_W     (ACC_W),
    .POS_W     (c_pos_w),
    .LIMIT     (H_ACTIVE),
    .RESET_POS (H_ACTIVE / 2)
  ) u_axis_x (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .add_en (w_add),
    .delta  (w_dx),
    .clear  (w_commit_x),
    .commit (w_commit_x),
    .pos    (x_pos),
    .sat    (w_sat_x)
  );

  cursor_axis_accum #(
    .ACC_W     (ACC_W),
    .POS_W     (c_pos_w),
    .LIMIT     (V_ACTIVE),
    .RESET_POS (V_ACTIVE / 2)
  ) u_axis_y (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .add_en (w_add),
    .delta  (w_dy),
    .clear  (w_commit_y),
    .commit (w_commit_y),
    .pos    (y_pos),
    .sat    (w_sat_y)
  );

  // Commit sequencer plus arbiter history, pending mouse buttons and sticky saturation flag
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ACCUM;
      r_rr_last  <= REQ_MS;
      r_btn_pend <= 3'b000;
      r_buttons  <= 3'b000;
      r_sat_flag <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          // A transfer accepted alongside the tick is already in the accumulators
          if (frame_tick) begin
            r_state <= COMMIT_X;
          end
        end
        COMMIT_X: begin
          r_state   <= COMMIT_Y;
          r_buttons <= r_btn_pend;
        end
        COMMIT_Y: begin
          r_state <= ACCUM;
        end
        default: begin
          r_state <= ACCUM;
        end
      endcase

      if (w_btn_grant) begin
        r_rr_last <= REQ_BTN;
      end
      if (w_ms_grant) begin
        r_rr_last  <= REQ_MS;
        r_btn_pend <= ms_buttons;
      end

      r_sat_flag <= r_sat_flag || w_sat_x || w_sat_y;
    end
  end

  assign buttons  = r_buttons;
  assign sat_flag = r_sat_flag;

endmodule : cursor_update_scheduler
`default_nettype wire

// File: tb/tb_cursor_update_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cursor_update_scheduler                                    |
// | Purpose  : Directed self-checking bench for cursor_update_scheduler.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_cursor_update_scheduler;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       btn_valid;
  logic       btn_ready;
  logic [8:0] btn_dx;
  logic [8:0] btn_dy;
  logic       ms_valid;
  logic       ms_ready;
  logic [8:0] ms_dx;
  logic [8:0] ms_dy;
  logic [2:0] ms_buttons;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [2:0] buttons;
  logic       sat_flag;

  int n_vec = 0;
  int n_err = 0;

  always #20 clk_in = ~clk_in;

  cursor_update_scheduler dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn_valid  (btn_valid),
    .btn_ready  (btn_ready),
    .btn_dx     (btn_dx),
    .btn_dy     (btn_dy),
    .ms_valid   (ms_valid),
    .ms_ready   (ms_ready),
    .ms_dx      (ms_dx),
    .ms_dy      (ms_dy),
    .ms_buttons (ms_buttons),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .buttons    (buttons),
    .sat_flag   (sat_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic btn_xfer(input int dx, input int dy);
    btn_valid = 1'b1;
    btn_dx    = 9'(dx);
    btn_dy    = 9'(dy);
    step();
    btn_valid = 1'b0;
  endtask

  task automatic do_frame(input string tag, input int ex, input int ey);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    check({tag, "_x"}, 32'(x_pos), 32'(ex));
    step();
    check({tag, "_y"}, 32'(y_pos), 32'(ey));
  endtask

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    btn_valid  = 1'b0;
    btn_dx     = '0;
    btn_dy     = '0;
    ms_valid   = 1'b0;
    ms_dx      = '0;
    ms_dy      = '0;
    ms_buttons = '0;

    // Reset values
    #50;
    check("rst_x", 32'(x_pos), 32'd320);
    check("rst_y", 32'(y_pos), 32'd240);
    check("rst_buttons", 32'(buttons), 32'd0);
    check("rst_readies", 32'({ms_ready, btn_ready}), 32'd0);
    check("rst_sat", 32'(sat_flag), 32'd0);
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    step();

    // Single button transfer, latency 2 (x) and 3 (y) after the tick
    btn_valid = 1'b1;
    btn_dx    = 9'(5);
    btn_dy    = 9'(3);
    #1;
    check("single_ready", 32'({ms_ready, btn_ready}), 32'd1);
    step();
    btn_valid  = 1'b0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    check("single_x", 32'(x_pos), 32'd325);
    check("single_y_early", 32'(y_pos), 32'd240);
    step();
    check("single_y", 32'(y_pos), 32'd243);

    // Contention: button was granted last, so the mouse goes first, then alternate
    btn_valid  = 1'b1;
    btn_dx     = 9'(1);
    btn_dy     = 9'(0);
    ms_valid   = 1'b1;
    ms_dx      = 9'(1);
    ms_dy      = 9'(1);
    ms_buttons = 3'b101;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_grant", 32'({ms_ready, btn_ready}), (i % 2 == 0) ? 32'd2 : 32'd1);
      step();
    end
    btn_valid = 1'b0;
    ms_valid  = 1'b0;
    do_frame("rr", 329, 241);
    check("rr_buttons", 32'(buttons), 32'd5);

    // Transfer on the tick cycle is committed; tick during commit is ignored
    btn_valid  = 1'b1;
    btn_dx     = 9'(7);
    btn_dy     = 9'(0);
    frame_tick = 1'b1;
    #1;
    check("edge_ready", 32'(btn_ready), 32'd1);
    step();
    btn_dx     = 9'(0);
    ms_valid   = 1'b1;
    ms_dx      = 9'(2);
    ms_dy      = 9'(0);
    ms_buttons = 3'b000;
    #1;
    check("edge_readies_cx", 32'({ms_ready, btn_ready}), 32'd0);
    step();
    frame_tick = 1'b0;
    check("edge_x", 32'(x_pos), 32'd336);
    check("edge_readies_cy", 32'({ms_ready, btn_ready}), 32'd0);
    step();
    check("edge_readies_back", 32'({ms_ready, btn_ready}), 32'd2);
    step();
    btn_valid = 1'b0;
    ms_valid  = 1'b0;
    step();
    step();
    step();
    check("no_queued_x", 32'(x_pos), 32'd336);
    check("no_queued_y", 32'(y_pos), 32'd241);

    // Clamp at both ends (pending +2 from the mouse transfer above)
    btn_xfer(255, -239);
    btn_xfer(37, 0);
    do_frame("pre_clamp", 630, 2);
    check("pre_clamp_buttons", 32'(buttons), 32'd0);
    btn_xfer(100, -50);
    do_frame("clamp", 639, 0);

    // Saturation: 20 x +255 holds the accumulator at +2047
    check("sat_before", 32'(sat_flag), 32'd0);
    btn_valid = 1'b1;
    btn_dx    = 9'(255);
    btn_dy    = 9'(0);
    repeat (20) step();
    btn_valid = 1'b0;
    check("sat_set", 32'(sat_flag), 32'd1);
    do_frame("sat", 639, 0);

    // Saturated value is +2047 exactly: 2047 - 9*255 = -248 -> x = 391
    btn_valid = 1'b1;
    btn_dx    = 9'(255);
    btn_dy    = 9'(0);
    repeat (20) step();
    btn_valid  = 1'b0;
    ms_valid   = 1'b1;
    ms_dx      = 9'(0);
    ms_dy      = 9'(0);
    ms_buttons = 3'b011;
    step();
    ms_valid  = 1'b0;
    btn_valid = 1'b1;
    btn_dx    = 9'(-255);
    repeat (9) step();
    btn_valid = 1'b0;
    do_frame("sat_hold", 391, 0);
    check("sat_hold_buttons", 32'(buttons), 32'd3);
    check("sat_sticky", 32'(sat_flag), 32'd1);

    // Reset in the middle of a commit discards everything
    btn_xfer(-100, 5);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    #5;
    rst_n = 1'b0;
    #1;
    check("midrst_x", 32'(x_pos), 32'd320);
    check("midrst_y", 32'(y_pos), 32'd240);
    check("midrst_buttons", 32'(buttons), 32'd0);
    check("midrst_sat", 32'(sat_flag), 32'd0);
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    step();
    do_frame("post_rst", 320, 240);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_cursor_update_scheduler
`default_nettype wire
